// File: rtl/multicycle_control_unit.sv
// Sequenced RV32I control unit: one instruction at a time through DECODE, EXEC, MEM and WB.
// Controls are decoded from the state and the latched instruction fields.
module multicycle_control_unit #(
    parameter bit          EN_IMM_OPS  = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  alu_control_signal,
    output logic        alu_src_imm,
    output logic        regwrite_control_signal,
    output logic        branch_eval,
    output logic        pc_update,
    output logic        illegal_instr,
    output logic        mem_err,
    output logic        busy
);
    localparam int unsigned OP_W  = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [OP_W-1:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OP_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_OPIMM,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_ILLEGAL
    } iclass_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [F3_W-1:0]   funct3_q, funct3_d;
    logic              bit30_q, bit30_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ALU_W-1:0]  alu_q, alu_d;
    iclass_e           iclass_c;
    logic [ALU_W-1:0]  alu_exec_c;
    logic              unused_instr_bits;

    // Register indices and immediates belong to the datapath; only opcode, funct3 and bit 30 are kept.
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            funct3_q <= '0;
            bit30_q  <= 1'b0;
            cnt_q    <= '0;
            alu_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct3_q <= funct3_d;
            bit30_q  <= bit30_d;
            cnt_q    <= cnt_d;
            alu_q    <= alu_d;
        end
    end

    // Instruction class of the latched word; reserved branch funct3 values are illegal.
    always_comb begin
        iclass_c = C_ILLEGAL;
        case (opcode_q)
            OPC_RTYPE:  iclass_c = C_RTYPE;
            OPC_OPIMM:  iclass_c = EN_IMM_OPS ? C_OPIMM : C_ILLEGAL;
            OPC_LOAD:   iclass_c = C_LOAD;
            OPC_STORE:  iclass_c = C_STORE;
            OPC_BRANCH: iclass_c = (funct3_q[2:1] == 2'b01) ? C_ILLEGAL : C_BRANCH;
            default:    iclass_c = C_ILLEGAL;
        endcase
    end

    always_comb begin
        alu_exec_c = '0;
        case (iclass_c)
            C_RTYPE: alu_exec_c = {bit30_q, funct3_q};
            C_OPIMM: alu_exec_c = {(funct3_q == 3'b101) & bit30_q, funct3_q};
            C_BRANCH: begin
                case (funct3_q[2:1])
                    2'b00:   alu_exec_c = 4'b1000;
                    2'b10:   alu_exec_c = 4'b0010;
                    default: alu_exec_c = 4'b0011;
                endcase
            end
            default: alu_exec_c = '0;
        endcase
    end

    always_comb begin
        state_d                 = state_q;
        opcode_d                = opcode_q;
        funct3_d                = funct3_q;
        bit30_d                 = bit30_q;
        cnt_d                   = cnt_q;
        alu_d                   = alu_q;
        instr_ready             = 1'b0;
        busy                    = 1'b1;
        mem_req                 = 1'b0;
        mem_we                  = 1'b0;
        alu_control_signal      = alu_q;
        alu_src_imm             = 1'b0;
        regwrite_control_signal = 1'b0;
        branch_eval             = 1'b0;
        pc_update               = 1'b0;
        illegal_instr           = 1'b0;
        mem_err                 = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy        = 1'b0;
                instr_ready = 1'b1;
                if (instr_valid) begin
                    opcode_d = instr[6:0];
                    funct3_d = instr[14:12];
                    bit30_d  = instr[30];
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (iclass_c == C_ILLEGAL) begin
                    illegal_instr = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_control_signal = alu_exec_c;
                alu_d              = alu_exec_c;
                cnt_d              = '0;
                case (iclass_c)
                    C_RTYPE: state_d = S_WB;
                    C_OPIMM: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_MEM;
                    end
                    C_BRANCH: begin
                        branch_eval = 1'b1;
                        pc_update   = 1'b1;
                        state_d     = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            // mem_ready is checked before the timeout so a last-cycle completion still retires.
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (iclass_c == C_STORE);
                if (mem_ready) begin
                    if (iclass_c == C_STORE) begin
                        pc_update = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_err = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                regwrite_control_signal = 1'b1;
                pc_update               = 1'b1;
                state_d                 = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a trace model predicts every output per cycle.
module tb_multicycle_control_unit;
    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       mem_req;
        logic       mem_we;
        logic [3:0] alu;
        logic       src;
        logic       regw;
        logic       br;
        logic       pcu;
        logic       ill;
        logic       merr;
    } obs_t;

    localparam int T_A = 16;
    localparam int T_B = 1;
    localparam int CL_R = 0, CL_I = 1, CL_LD = 2, CL_ST = 3, CL_BR = 4, CL_ILL = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

    logic        valid_a, ready_a, mem_ready_a, mem_req_a, mem_we_a, src_a;
    logic        regw_a, br_a, pcu_a, ill_a, merr_a, busy_a;
    logic [31:0] instr_a;
    logic [3:0]  alu_a;
    logic        valid_b, ready_b, mem_ready_b, mem_req_b, mem_we_b, src_b;
    logic        regw_b, br_b, pcu_b, ill_b, merr_b, busy_b;
    logic [31:0] instr_b;
    logic [3:0]  alu_b;
    obs_t        obs_a, obs_b;

    logic [3:0]  hold_a = 4'h0;
    logic [3:0]  hold_b = 4'h0;
    obs_t        exp_q[$];
    obs_t        tr_q[$];
    int          mr_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_control_unit #(.EN_IMM_OPS(1'b1), .MEM_TIMEOUT(T_A)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(valid_a), .instr_ready(ready_a),
        .instr(instr_a), .mem_ready(mem_ready_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
        .alu_control_signal(alu_a), .alu_src_imm(src_a), .regwrite_control_signal(regw_a),
        .branch_eval(br_a), .pc_update(pcu_a), .illegal_instr(ill_a), .mem_err(merr_a),
        .busy(busy_a)
    );

    multicycle_control_unit #(.EN_IMM_OPS(1'b0), .MEM_TIMEOUT(T_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .instr_valid(valid_b), .instr_ready(ready_b),
        .instr(instr_b), .mem_ready(mem_ready_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
        .alu_control_signal(alu_b), .alu_src_imm(src_b), .regwrite_control_signal(regw_b),
        .branch_eval(br_b), .pc_update(pcu_b), .illegal_instr(ill_b), .mem_err(merr_b),
        .busy(busy_b)
    );

    assign obs_a = {ready_a, busy_a, mem_req_a, mem_we_a, alu_a, src_a, regw_a, br_a, pcu_a, ill_a, merr_a};
    assign obs_b = {ready_b, busy_b, mem_req_b, mem_we_b, alu_b, src_b, regw_b, br_b, pcu_b, ill_b, merr_b};

    function automatic obs_t idle_obs(input logic [3:0] hold);
        obs_t o;
        o       = '0;
        o.ready = 1'b1;
        o.alu   = hold;
        return o;
    endfunction

    // Fills tr_q with the expected outputs of cycles 1..N after accept, and mr_q with the
    // mem_ready to drive in each of those cycles (2 = free). w = MEM cycles with mem_ready low.
    function automatic logic [3:0] build_trace(input logic [31:0] ins, input int w,
                                               input bit en_imm, input int t, input logic [3:0] hold);
        obs_t       base, r;
        logic [2:0] f3;
        logic [3:0] a;
        int         cls, m;
        f3 = ins[14:12];
        tr_q.delete();
        mr_q.delete();
        case (ins[6:0])
            7'b0110011: cls = CL_R;
            7'b0010011: cls = en_imm ? CL_I : CL_ILL;
            7'b0000011: cls = CL_LD;
            7'b0100011: cls = CL_ST;
            7'b1100011: cls = (f3 == 3'd2 || f3 == 3'd3) ? CL_ILL : CL_BR;
            default:    cls = CL_ILL;
        endcase
        base      = '0;
        base.busy = 1'b1;
        base.alu  = hold;
        r         = base;
        r.ill     = (cls == CL_ILL);
        tr_q.push_back(r);
        mr_q.push_back(2);
        if (cls == CL_ILL) return hold;
        case (cls)
            CL_R:    a = {ins[30], f3};
            CL_I:    a = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
            CL_BR:   a = (f3 < 3'd4) ? 4'b1000 : ((f3 < 3'd6) ? 4'b0010 : 4'b0011);
            default: a = 4'b0000;
        endcase
        r     = base;
        r.alu = a;
        r.src = (cls == CL_I || cls == CL_LD || cls == CL_ST);
        r.br  = (cls == CL_BR);
        r.pcu = (cls == CL_BR);
        tr_q.push_back(r);
        mr_q.push_back(2);
        if (cls == CL_BR) return a;
        base.alu = a;
        if (cls == CL_R || cls == CL_I) begin
            r      = base;
            r.regw = 1'b1;
            r.pcu  = 1'b1;
            tr_q.push_back(r);
            mr_q.push_back(2);
            return a;
        end
        m = (w < t) ? w + 1 : t;
        for (int i = 1; i <= m; i++) begin
            r         = base;
            r.mem_req = 1'b1;
            r.mem_we  = (cls == CL_ST);
            if (i == m) begin
                if (w < t) r.pcu = (cls == CL_ST);
                else       r.merr = 1'b1;
            end
            tr_q.push_back(r);
            mr_q.push_back((i == w + 1) ? 1 : 0);
        end
        if (cls == CL_LD && w < t) begin
            r      = base;
            r.regw = 1'b1;
            r.pcu  = 1'b1;
            tr_q.push_back(r);
            mr_q.push_back(2);
        end
        return a;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b (rdy,busy,req,we,alu,src,regw,br,pcu,ill,merr)",
                     name, cyc, got, want);
        end
    endtask

    // Monitor: every cycle compares the DUT against the next expected record, or idle when none.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (exp_q.size() > 0) check("a_cycle", obs_a, exp_q.pop_front());
            else                  check("a_idle", obs_a, idle_obs(hold_a));
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        int          sel;
        x   = $urandom;
        sel = $urandom_range(0, 6);
        case (sel)
            0:       x[6:0] = 7'b0110011;
            1:       x[6:0] = 7'b0010011;
            2:       x[6:0] = 7'b0000011;
            3:       x[6:0] = 7'b0100011;
            4, 5:    x[6:0] = 7'b1100011;
            default: x[6:0] = 7'($urandom);
        endcase
        return x;
    endfunction

    // Offer one instruction to DUT A (called at posedge+1 with A idle) and drive it to completion.
    task automatic issue_a(input logic [31:0] ins, input int w);
        int mrl[$];
        valid_a = 1'b1;
        instr_a = ins;
        @(posedge clk);
        hold_a = build_trace(ins, w, 1'b1, T_A, hold_a);
        foreach (tr_q[i]) exp_q.push_back(tr_q[i]);
        mrl = mr_q;
        for (int k = 0; k < mrl.size(); k++) begin
            #1;
            valid_a     = 1'($urandom_range(0, 1));
            instr_a     = $urandom;
            mem_ready_a = (mrl[k] == 2) ? 1'($urandom_range(0, 1)) : 1'(mrl[k]);
            @(posedge clk);
        end
        #1;
        valid_a     = 1'b0;
        mem_ready_a = 1'($urandom_range(0, 1));
    endtask

    // DUT B (no OP-IMM, one-cycle timeout) is checked cycle by cycle, including the idle cycle after.
    task automatic run_b(input logic [31:0] ins, input int w);
        obs_t bq[$];
        int   mrl[$];
        obs_t e;
        valid_b = 1'b1;
        instr_b = ins;
        @(posedge clk);
        hold_b = build_trace(ins, w, 1'b0, T_B, hold_b);
        bq  = tr_q;
        mrl = mr_q;
        for (int k = 0; k <= bq.size(); k++) begin
            #1;
            valid_b     = 1'b0;
            mem_ready_b = (k < mrl.size()) ? ((mrl[k] == 2) ? 1'b0 : 1'(mrl[k])) : 1'b0;
            @(negedge clk);
            e = (k < bq.size()) ? bq[k] : idle_obs(hold_b);
            check("b_cycle", obs_b, e);
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        logic [31:0] ins;
        int          w;
        rst_n       = 1'b1;
        valid_a     = 1'b0;
        instr_a     = '0;
        mem_ready_a = 1'b0;
        valid_b     = 1'b0;
        instr_b     = '0;
        mem_ready_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_a", obs_a, idle_obs(4'h0));
        check("reset_b", obs_b, idle_obs(4'h0));
        #9 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue_a(32'h002081B3, 0);     // add
        issue_a(32'h402081B3, 0);     // sub
        issue_a(32'h0050E193, 0);     // ori
        issue_a(32'h0000A283, 3);     // lw, three wait cycles
        issue_a(32'h0020A023, 100);   // sw, never completes
        issue_a(32'h00208063, 0);     // beq
        issue_a(32'hFFFFFFFF, 0);     // illegal
        issue_a(32'h0000A283, T_A - 1); // ready on the timeout cycle
        issue_a(32'h0020A023, 0);     // sw, immediate completion
        issue_a(32'h0020A063 | 32'h00002000, 0); // branch funct3=010

        run_b(32'h0050E193, 0);       // ori illegal without OP-IMM support
        run_b(32'h002081B3, 0);
        run_b(32'h0020A023, 5);       // timeout on first MEM cycle
        run_b(32'h0000A283, 0);       // ready beats one-cycle timeout

        for (int i = 0; i < 200; i++) begin
            ins = rand_instr();
            w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
            issue_a(ins, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset in the middle of a MEM wait
        valid_a = 1'b1;
        instr_a = 32'h0000A283;
        @(posedge clk);
        hold_a = build_trace(32'h0000A283, 100, 1'b1, T_A, hold_a);
        foreach (tr_q[i]) exp_q.push_back(tr_q[i]);
        for (int k = 0; k < 4; k++) begin
            #1;
            valid_a     = 1'b0;
            mem_ready_a = 1'b0;
            @(posedge clk);
        end
        #3 rst_n = 1'b0;
        #1;
        check("abort_a", obs_a, idle_obs(4'h0));
        check("abort_b", obs_b, idle_obs(4'h0));
        exp_q.delete();
        hold_a = 4'h0;
        hold_b = 4'h0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue_a(32'h002081B3, 0);
        issue_a(32'h0050E193, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
